// File: rtl/sd_cmd_tx_if.sv
// Bus bundle for the SD CMD-line transmitter: command request in, serial line and status out.
interface sd_cmd_tx_if;
  logic        start;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        sclk_en;
  logic        cmd_out;
  logic        cmd_oe;
  logic        busy;
  logic        done;

  modport master (
    output start, cmd_index, cmd_arg, sclk_en,
    input  cmd_out, cmd_oe, busy, done
  );

  modport slave (
    input  start, cmd_index, cmd_arg, sclk_en,
    output cmd_out, cmd_oe, busy, done
  );
endinterface

// File: rtl/sd_cmd_tx.sv
// SD command transmitter: serialises a 48-bit command frame (with CRC7) onto the CMD line,
// one bit per sclk_en strobe, MSB first.
//
// state | meaning
// IDLE  | line released (oe=0, out=1); waiting for start
// SHIFT | driving bits 0-39 (start, transmission, index, argument)
// CRC   | driving bits 40-46 (CRC7)
// STOP  | driving bit 47 (end bit)
// DONE  | one-cycle completion pulse, line released
module sd_cmd_tx (
  input  logic        clk,
  input  logic        n_rst,
  sd_cmd_tx_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, SHIFT, CRC, STOP, DONE} state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt, cnt_nxt;
  logic [5:0]  idx_q;
  logic [31:0] arg_q;
  logic [6:0]  crc_q;
  logic        out_q, out_nxt;
  logic        oe_q, oe_nxt;
  logic        busy_q, busy_nxt;
  logic        done_q, done_nxt;
  logic        capture;
  logic [47:0] frame;

  // CRC is formed at capture so it is settled long before bit 40 goes out.
  function automatic logic [6:0] crc7(input logic [39:0] msg);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = msg[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  assign frame = {2'b01, idx_q, arg_q, crc_q, 1'b1};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    out_nxt   = out_q;
    oe_nxt    = oe_q;
    busy_nxt  = busy_q;
    done_nxt  = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        oe_nxt   = 1'b0;
        out_nxt  = 1'b1;
        busy_nxt = 1'b0;
        if (bus.start) begin
          capture   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = SHIFT;
          oe_nxt    = 1'b1;
          busy_nxt  = 1'b1;
          out_nxt   = 1'b0;
        end
      end
      SHIFT, CRC, STOP: begin
        oe_nxt   = 1'b1;
        busy_nxt = 1'b1;
        if (bus.sclk_en) begin
          if (state == STOP) begin
            state_nxt = DONE;
            cnt_nxt   = '0;
            done_nxt  = 1'b1;
            oe_nxt    = 1'b0;
            out_nxt   = 1'b1;
            busy_nxt  = 1'b0;
          end else begin
            cnt_nxt = cnt + 6'd1;
            out_nxt = frame[6'd47 - cnt_nxt];
            if (state == SHIFT && cnt == 6'd39) state_nxt = CRC;
            if (state == CRC && cnt == 6'd46)   state_nxt = STOP;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
        oe_nxt    = 1'b0;
        out_nxt   = 1'b1;
        busy_nxt  = 1'b0;
      end
      default: begin
        state_nxt = IDLE;
        oe_nxt    = 1'b0;
        out_nxt   = 1'b1;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state  <= IDLE;
      cnt    <= '0;
      idx_q  <= '0;
      arg_q  <= '0;
      crc_q  <= '0;
      out_q  <= 1'b1;
      oe_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      out_q  <= out_nxt;
      oe_q   <= oe_nxt;
      busy_q <= busy_nxt;
      done_q <= done_nxt;
      if (capture) begin
        idx_q <= bus.cmd_index;
        arg_q <= bus.cmd_arg;
        crc_q <= crc7({2'b01, bus.cmd_index, bus.cmd_arg});
      end
    end
  end

  assign bus.cmd_out = out_q;
  assign bus.cmd_oe  = oe_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule
